add_subt_responder_fsm: RTL and testbench

//   Multi-cycle signed fixed-point adder/subtractor with handshake control; the responder end of
//   the CORDIC controller's add/subtract handshake (beg_add_subt / ack_add_subt in, ready_add_subt out).

---
 rtl/add_subt_responder_fsm.sv | 104 ++++++++++
 tb/tb_add_subt_responder_fsm.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/add_subt_responder_fsm.sv
// Multi-cycle signed adder/subtractor answering the CORDIC add/subtract handshake.
// Optional saturation on overflow: define ADD_SUBT_SAT_EN.
module add_subt_responder_fsm #(
  parameter int W       = 32,
  parameter int LATENCY = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         beg_add_subt,
  input  logic         ack_add_subt,
  input  logic         add_subt,
  input  logic [W-1:0] Data_X,
  input  logic [W-1:0] Data_Y,
  output logic         ready_add_subt,
  output logic         busy_add_subt,
  output logic [W-1:0] Data_Result,
  output logic         overflow_flag,
  output logic [1:0]   fsm_state
);

  // Handshake: beg_add_subt is honoured only in IDLE and ack_add_subt only in READY;
  // ready_add_subt stays high with a stable result until the edge that samples ack.

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     x_q, y_q;
  logic             sub_q;

  logic [W-1:0]     y_eff;
  logic [W:0]       sum_ext;
  logic [W-1:0]     res_wrap;
  logic [W-1:0]     res_final;
  logic             ovf_c;
  logic             unused_carry;

  assign fsm_state = state;

  // Subtraction as X + ~Y + 1 at W+1 bits; the extra bit is not needed for the W-bit result.
  always_comb begin
    y_eff        = sub_q ? ~y_q : y_q;
    sum_ext      = {x_q[W-1], x_q} + {y_eff[W-1], y_eff} + {{W{1'b0}}, sub_q};
    res_wrap     = sum_ext[W-1:0];
    unused_carry = sum_ext[W];
    ovf_c        = (x_q[W-1] == y_eff[W-1]) && (res_wrap[W-1] != x_q[W-1]);
`ifdef ADD_SUBT_SAT_EN
    // On overflow both operands share the sign of X, so X decides the saturation direction.
    if (ovf_c)
      res_final = x_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      res_final = res_wrap;
`else
    res_final = res_wrap;
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (beg_add_subt) state_next = CALC;
      CALC:    if (cnt == '0) state_next = READY;
      READY:   if (ack_add_subt) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      x_q            <= '0;
      y_q            <= '0;
      sub_q          <= 1'b0;
      Data_Result    <= '0;
      overflow_flag  <= 1'b0;
      ready_add_subt <= 1'b0;
      busy_add_subt  <= 1'b0;
    end else begin
      state          <= state_next;
      busy_add_subt  <= (state_next != IDLE);
      ready_add_subt <= (state_next == READY);
      if (state == IDLE && beg_add_subt) begin
        x_q   <= Data_X;
        y_q   <= Data_Y;
        sub_q <= add_subt;
        cnt   <= CNT_W'(LATENCY - 1);
      end else if (state == CALC && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (state == CALC && cnt == '0) begin
        Data_Result   <= res_final;
        overflow_flag <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_add_subt_responder_fsm.sv
// Directed bench for add_subt_responder_fsm: stimulus pushes expected {ovf, result},
// a negedge monitor pops and compares on every rising ready_add_subt.
module tb_add_subt_responder_fsm;

  localparam int W       = 32;
  localparam int LATENCY = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         beg_add_subt;
  logic         ack_add_subt;
  logic         add_subt;
  logic [W-1:0] Data_X;
  logic [W-1:0] Data_Y;
  logic         ready_add_subt;
  logic         busy_add_subt;
  logic [W-1:0] Data_Result;
  logic         overflow_flag;
  logic [1:0]   fsm_state;

  logic [W:0]   exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic         ready_prev = 1'b0;

  // Clock / reset
  always #5 clk = ~clk;

  add_subt_responder_fsm #(.W(W), .LATENCY(LATENCY)) dut (
    .clk            (clk),
    .reset          (reset),
    .beg_add_subt   (beg_add_subt),
    .ack_add_subt   (ack_add_subt),
    .add_subt       (add_subt),
    .Data_X         (Data_X),
    .Data_Y         (Data_Y),
    .ready_add_subt (ready_add_subt),
    .busy_add_subt  (busy_add_subt),
    .Data_Result    (Data_Result),
    .overflow_flag  (overflow_flag),
    .fsm_state      (fsm_state)
  );

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (ready_add_subt && !ready_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%0h ovf %0b with no operation pending at %0t",
                 Data_Result, overflow_flag, $time);
      end else begin
        check("result", {overflow_flag, Data_Result}, exp_q.pop_front());
      end
    end
    ready_prev = ready_add_subt;
  end

  // Driver tasks: all called at a negedge and return at a negedge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    Data_X       = x;
    Data_Y       = y;
    add_subt     = s;
    beg_add_subt = 1'b1;
    @(negedge clk);
    beg_add_subt = 1'b0;
    Data_X       = $urandom;
    Data_Y       = $urandom;
    add_subt     = 1'($urandom_range(0, 1));
    check("busy_after_start", {32'd0, busy_add_subt}, 33'd1);
  endtask

  task automatic wait_result(input logic noise);
    for (int i = 1; i < LATENCY; i++) begin
      if (noise) begin
        beg_add_subt = 1'($urandom_range(0, 1));
        Data_X       = $urandom;
        Data_Y       = $urandom;
      end
      @(negedge clk);
      check("ready_early", {32'd0, ready_add_subt}, 33'd0);
    end
    @(negedge clk);
    beg_add_subt = 1'b0;
    check("ready_at_latency", {32'd0, ready_add_subt}, 33'd1);
  endtask

  task automatic ack_op();
    ack_add_subt = 1'b1;
    @(negedge clk);
    ack_add_subt = 1'b0;
    check("ready_after_ack", {32'd0, ready_add_subt}, 33'd0);
    check("busy_after_ack", {32'd0, busy_add_subt}, 33'd0);
  endtask

  task automatic full_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input logic [W-1:0] r, input logic v);
    exp_q.push_back({v, r});
    start_op(x, y, s);
    wait_result(1'b0);
    ack_op();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    beg_add_subt = 1'b0;
    ack_add_subt = 1'b0;
    add_subt     = 1'b0;
    Data_X       = '0;
    Data_Y       = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_ready", {32'd0, ready_add_subt}, 33'd0);
    check("reset_busy", {32'd0, busy_add_subt}, 33'd0);
    check("reset_result", {overflow_flag, Data_Result}, 33'd0);
    check("reset_state", {31'd0, fsm_state}, 33'd0);

    // 1: simple add, hold two cycles before ack
    exp_q.push_back({1'b0, 32'h00000008});
    start_op(32'h00000005, 32'h00000003, 1'b0);
    wait_result(1'b0);
    repeat (2) begin
      @(negedge clk);
      check("hold_ready", {32'd0, ready_add_subt}, 33'd1);
      check("hold_result", {overflow_flag, Data_Result}, {1'b0, 32'h00000008});
    end
    ack_op();
    check("result_kept_after_ack", {overflow_flag, Data_Result}, {1'b0, 32'h00000008});

    // 2: subtract to a negative value; carry without overflow; equal minimums
    full_op(32'h00000005, 32'h00000008, 1'b1, 32'hFFFFFFFD, 1'b0);
    full_op(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFD, 1'b0);
    full_op(32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 1'b0);

    // 3: overflow in both directions
`ifdef ADD_SUBT_SAT_EN
    full_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1);
    full_op(32'h80000000, 32'h00000001, 1'b1, 32'h80000000, 1'b1);
    full_op(32'h00000000, 32'h80000000, 1'b1, 32'h7FFFFFFF, 1'b1);
`else
    full_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b1);
    full_op(32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1);
    full_op(32'h00000000, 32'h80000000, 1'b1, 32'h80000000, 1'b1);
`endif

    // 4: input noise during CALC/READY, long ack delay, back-to-back restart
    exp_q.push_back({1'b0, 32'h00000008});
    start_op(32'h00000005, 32'h00000003, 1'b0);
    wait_result(1'b1);
    for (int i = 0; i < 10; i++) begin
      beg_add_subt = 1'($urandom_range(0, 1));
      Data_X       = $urandom;
      Data_Y       = $urandom;
      @(negedge clk);
      check("noise_result", {overflow_flag, Data_Result}, {1'b0, 32'h00000008});
      check("noise_busy", {31'd0, busy_add_subt, ready_add_subt}, 33'd3);
    end
    beg_add_subt = 1'b0;
    ack_op();
    full_op(32'h00000010, 32'h00000020, 1'b0, 32'h00000030, 1'b0);

    // 5: reset during CALC with cnt == 1 aborts without a result
    start_op(32'h12345678, 32'h00000001, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", {32'd0, ready_add_subt}, 33'd0);
    check("abort_busy", {32'd0, busy_add_subt}, 33'd0);
    check("abort_result", {overflow_flag, Data_Result}, 33'd0);
    check("abort_state", {31'd0, fsm_state}, 33'd0);
    full_op(32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0);

    // 6: ack in IDLE is ignored; beg+ack in READY takes only the ack
    ack_add_subt = 1'b1;
    @(negedge clk);
    ack_add_subt = 1'b0;
    check("idle_ack_busy", {31'd0, busy_add_subt, ready_add_subt}, 33'd0);
    check("idle_ack_result", {overflow_flag, Data_Result}, {1'b0, 32'h00000003});
    exp_q.push_back({1'b0, 32'h000000FF});
    start_op(32'h00000100, 32'h00000001, 1'b1);
    wait_result(1'b0);
    beg_add_subt = 1'b1;
    ack_add_subt = 1'b1;
    @(negedge clk);
    beg_add_subt = 1'b0;
    ack_add_subt = 1'b0;
    check("beg_ack_ready", {32'd0, ready_add_subt}, 33'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("beg_ack_no_start", {31'd0, busy_add_subt, ready_add_subt}, 33'd0);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 33'(exp_q.size()), 33'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
